shift_rows_pipe: RTL and testbench
==================================

# shift_rows_pipe

Registered, handshaked ShiftRows/InvShiftRows stage for the AES/Rijndael datapath.
- Generalises the fixed 128-bit combinational byte rotation to Rijndael block widths of 4, 6 or 8 columns.
- Direction (forward/inverse) is selectable per transfer.
- A sideband tag travels alongside each state.
- Full-throughput valid/ready pipelining with a skid buffer, so the block drops between SubBytes and MixColumns (or their inverses) in a pipelined round.

## Interface
- NB, default 4: state columns; legal values 4, 6, 8 (state width 32*NB bits); any other value is a compile-time error.
- TAG_W, default 4: width of the sideband tag (round number / key slot), passed through unchanged.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; one clock, asynchronous, active-high.
- in_valid  in  1  input state valid.
- in_ready  out  1  block can accept an input this cycle.
- in_data  in  32*NB  input state.
- in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows for this transfer.
- in_tag  in  TAG_W  sideband, captured with in_data.
- out_valid  out  1  output state valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  32*NB  shifted state.
- out_tag  out  TAG_W  tag of the transfer in out_data.

## Operation
- Byte mapping, MSB-first column-major: state byte (row r, column c), k = 4*c + r, occupies bits [(4*NB-1-k)*8 +: 8]. Identical for in_data and out_data.
- Row offsets:
  - NB=4 and NB=6: row 0..3 = 0, 1, 2, 3.
  - NB=8: 0, 1, 3, 4.
- Forward: out(r,c) = in(r, (c + off_r) mod NB).
- Inverse: out(r,c) = in(r, (c - off_r + NB) mod NB).
- Row 0 always passes through unchanged.
- The transform is applied combinationally on the input side. The shifted result, not the raw input, is what is registered.
- Storage is two entries:
  - Output register: out_valid, out_data, out_tag.
  - Skid register: skid_valid, skid_data, skid_tag.
- in_ready = !skid_valid, driven from a register with no combinational path from out_ready.
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Per-cycle behaviour:
  - Input accepted, output register empty or draining this cycle: the result loads into the output register.
  - Input accepted, output register full and stalled: the result loads into the skid register and skid_valid sets.
  - Output drains while skid_valid: the skid entry moves into the output register and skid_valid clears, whether or not a new input also arrives. No new input can arrive in that cycle because in_ready=0.
  - out_valid clears only on an output transfer with no replacement data.
- Ordering is strictly FIFO. No transfer is ever dropped or duplicated.
- in_inv and in_tag are sampled only on an input transfer. A change while in_ready=0 has no effect.
- out_data and out_tag are held stable while out_valid && !out_ready.

## Timing
- Latency: 1 cycle. A state accepted at edge N appears on out_data after edge N, valid for the cycle following N.
- Throughput: one state per cycle while out_ready=1.
- in_ready deasserts one cycle after the first stalled cycle in which an input was also accepted. It reasserts the cycle after the skid entry moves out.
- Reset, asynchronous, takes effect immediately:
  - out_valid=0, skid_valid=0, in_ready=1.
  - out_data=0, out_tag=0, skid contents=0.
- Reset mid-operation discards both entries with no output transfer. The first valid output after release is the first input accepted after release.
- in_valid is ignored while rst=1.
- No protocol state beyond the two valid bits.
  - EMPTY: out_valid=0, skid_valid=0.
  - ONE: out_valid=1, skid_valid=0.
  - FULL: out_valid=1, skid_valid=1.
- State transitions:
  - EMPTY -> ONE on input.
  - ONE -> FULL on input without drain.
  - ONE -> EMPTY on drain without input.
  - FULL -> ONE on drain.
  - FULL -> EMPTY is impossible in one cycle.

## Test plan
- NB=4, forward, FIPS-197 App. B round 1: in_data=d42711aee0bf98f1b8b45de51e415230 -> out_data=d4bf5d30e0b452aeb84111f11e2798e5, one cycle later, tag preserved.
- NB=4, inverse: in_data=d4bf5d30e0b452aeb84111f11e2798e5 -> d42711aee0bf98f1b8b45de51e415230. Also in_data=000102…0f, forward -> 00050a0f04090e03080d02070c01060b.
- NB=8, forward, in_data=bytes 00..1f: first output column must be 00 05 0e 13, checking the row 2/3 offsets of 3 and 4. Inverse of that result must return the original bytes exactly.
- Backpressure: stream 16 states with alternating in_inv and out_ready low for 3 cycles mid-stream. Required:
  - in_ready falls exactly one cycle after the stall begins with an input accepted.
  - No loss, no duplication, order preserved.
  - out_data is stable while stalled.
- Full throughput: out_ready=1 and in_valid=1 for 20 cycles -> 20 outputs on 20 consecutive cycles, in_ready constantly 1.
- Reset mid-stream: assert rst asynchronously while FULL -> out_valid=0, in_ready=1, out_data=0 immediately. After release, the first output equals the first post-reset input.

Source files
------------

// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows/InvShiftRows stage for Rijndael states of 4, 6 or 8 columns,
// with a valid/ready handshake, a sideband tag and a one-entry skid buffer.
module shift_rows_pipe #(
  parameter int unsigned NB    = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [32*NB-1:0]   in_data,
  input  logic               in_inv,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [32*NB-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : gen_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  logic [W-1:0] fwd_data;
  logic [W-1:0] inv_data;
  logic [W-1:0] shifted;

  // Byte (r,c) sits at index k = 4*c + r counted from the MSB end.
  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int unsigned Off = (NB == 8 && r >= 2) ? r + 1 : r;
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int unsigned SrcF = (c + Off) % NB;
      localparam int unsigned SrcI = (c + NB - Off) % NB;
      localparam int unsigned Dst  = (4 * NB - 1 - (4 * c + r)) * 8;
      assign fwd_data[Dst +: 8] = in_data[(4 * NB - 1 - (4 * SrcF + r)) * 8 +: 8];
      assign inv_data[Dst +: 8] = in_data[(4 * NB - 1 - (4 * SrcI + r)) * 8 +: 8];
    end
  end

  assign shifted = in_inv ? inv_data : fwd_data;

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             skid_valid_q, skid_valid_d;
  logic [W-1:0]     skid_data_q, skid_data_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid && !skid_valid_q;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_tag_d    = out_tag_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_tag_d   = skid_tag_q;
    if (out_fire && skid_valid_q) begin
      // in_ready is low here, so no new input competes with the skid entry.
      out_data_d   = skid_data_q;
      out_tag_d    = skid_tag_q;
      skid_valid_d = 1'b0;
    end else if (in_fire && (!out_valid_q || out_ready)) begin
      out_valid_d = 1'b1;
      out_data_d  = shifted;
      out_tag_d   = in_tag;
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = shifted;
      skid_tag_d   = in_tag;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_tag_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_tag_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_tag_q    <= out_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

  assign in_ready  = !skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench for shift_rows_pipe: known-answer vectors for NB=4 and NB=8, plus
// backpressure, full-throughput and asynchronous-reset sequences against a FIFO scoreboard.
module tb_shift_rows_pipe;

  localparam logic [127:0] VecA  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] VecB  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] VecC  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] VecCs = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [255:0] Vec8  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] Vec8s =
    256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, in_inv, out_valid, out_ready;
  logic [127:0] in_data, out_data;
  logic [3:0]   in_tag, out_tag;

  logic         in8_valid, in8_ready, in8_inv, out8_valid;
  logic [255:0] in8_data, out8_data;
  logic [3:0]   in8_tag, out8_tag;

  shift_rows_pipe #(.NB(4), .TAG_W(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  shift_rows_pipe #(.NB(8), .TAG_W(4)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in8_valid),
    .in_ready  (in8_ready),
    .in_data   (in8_data),
    .in_inv    (in8_inv),
    .in_tag    (in8_tag),
    .out_valid (out8_valid),
    .out_ready (1'b1),
    .out_data  (out8_data),
    .out_tag   (out8_tag)
  );

  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;
  int unsigned  out_cnt = 0;
  logic [131:0] sb_q[$];
  logic         stalled = 1'b0;
  logic [127:0] held_data;
  logic [3:0]   held_tag;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle, entered and left at a falling edge: check state, drive, update scoreboard.
  task automatic step(input logic v, input logic [127:0] d, input logic inv,
                      input logic [3:0] tg, input logic ordy, input logic [127:0] exp_d,
                      output logic acc);
    logic         in_fire, out_fire;
    logic [131:0] e;
    check_eq("out_valid", {255'd0, out_valid}, {255'd0, sb_q.size() != 0});
    check_eq("in_ready", {255'd0, in_ready}, {255'd0, sb_q.size() < 2});
    if (stalled) begin
      check_eq("hold_data", {128'd0, out_data}, {128'd0, held_data});
      check_eq("hold_tag", {252'd0, out_tag}, {252'd0, held_tag});
    end
    in_valid  = v;
    in_data   = d;
    in_inv    = inv;
    in_tag    = tg;
    out_ready = ordy;
    out_fire  = (sb_q.size() != 0) && ordy;
    in_fire   = v && (sb_q.size() < 2);
    stalled   = (sb_q.size() != 0) && !ordy;
    held_data = out_data;
    held_tag  = out_tag;
    if (out_fire) begin
      e = sb_q.pop_front();
      out_cnt++;
      check_eq("out_data", {128'd0, out_data}, {128'd0, e[127:0]});
      check_eq("out_tag", {252'd0, out_tag}, {252'd0, e[131:128]});
    end
    if (in_fire) sb_q.push_back({tg, exp_d});
    acc = in_fire;
    @(negedge clk);
  endtask

  task automatic drain();
    logic acc;
    int   k = 0;
    while (sb_q.size() != 0 && k < 20) begin
      step(1'b0, 128'd0, 1'b0, 4'd0, 1'b1, 128'd0, acc);
      k++;
    end
    check_eq("drain_empty", 256'(sb_q.size()), 256'd0);
  endtask

  initial begin
    logic         acc;
    logic [127:0] m;
    logic [7:0]   ib;
    int           i, cyc, c0;

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_inv = 1'b0; in_tag = '0; out_ready = 1'b0;
    in8_valid = 1'b0; in8_data = '0; in8_inv = 1'b0; in8_tag = '0;
    #1;
    check_eq("rst_out_valid", {255'd0, out_valid}, 256'd0);
    check_eq("rst_in_ready", {255'd0, in_ready}, 256'd1);
    check_eq("rst_out_data", {128'd0, out_data}, 256'd0);
    check_eq("rst_out_tag", {252'd0, out_tag}, 256'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Known-answer vectors, back to back.
    step(1'b1, VecA, 1'b0, 4'h5, 1'b1, VecB, acc);
    step(1'b1, VecB, 1'b1, 4'ha, 1'b1, VecA, acc);
    step(1'b1, VecC, 1'b0, 4'h3, 1'b1, VecCs, acc);
    drain();

    // NB=8: row 2/3 offsets of 3 and 4, then the inverse back.
    in8_valid = 1'b1; in8_data = Vec8; in8_inv = 1'b0; in8_tag = 4'h7;
    @(negedge clk);
    in8_valid = 1'b0;
    check_eq("nb8_fwd_valid", {255'd0, out8_valid}, 256'd1);
    check_eq("nb8_fwd_data", out8_data, Vec8s);
    check_eq("nb8_fwd_tag", {252'd0, out8_tag}, 256'd7);
    in8_valid = 1'b1; in8_data = Vec8s; in8_inv = 1'b1; in8_tag = 4'h9;
    @(negedge clk);
    in8_valid = 1'b0;
    check_eq("nb8_inv_data", out8_data, Vec8);
    check_eq("nb8_inv_tag", {252'd0, out8_tag}, 256'd9);
    @(negedge clk);
    check_eq("nb8_idle", {255'd0, out8_valid}, 256'd0);

    // Backpressure: 16 states, alternating direction, out_ready low for 3 cycles.
    i = 0;
    cyc = 0;
    while (i < 16 && cyc < 100) begin
      ib = 8'(i);
      m  = {16{ib}};
      if (i % 2 == 0)
        step(1'b1, VecA ^ m, 1'b0, ib[3:0], !(cyc >= 4 && cyc < 7), VecB ^ m, acc);
      else
        step(1'b1, VecB ^ m, 1'b1, ib[3:0], !(cyc >= 4 && cyc < 7), VecA ^ m, acc);
      if (acc) i++;
      cyc++;
    end
    check_eq("bp_accepted", 256'(i), 256'd16);
    drain();

    // Full throughput: 20 inputs, 20 outputs on consecutive cycles.
    c0 = out_cnt;
    for (int j = 0; j < 20; j++) begin
      ib = 8'(j + 32);
      m  = {16{ib}};
      step(1'b1, VecC ^ m, 1'b0, ib[3:0], 1'b1, VecCs ^ m, acc);
      check_eq("tp_accept", {255'd0, acc}, 256'd1);
    end
    step(1'b0, 128'd0, 1'b0, 4'd0, 1'b1, 128'd0, acc);
    check_eq("tp_outputs", 256'(out_cnt - c0), 256'd20);

    // Fill to FULL, then reset asynchronously mid-cycle.
    step(1'b1, VecA, 1'b0, 4'h1, 1'b0, VecB, acc);
    step(1'b1, VecB, 1'b1, 4'h2, 1'b0, VecA, acc);
    check_eq("full_in_ready", {255'd0, in_ready}, 256'd0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_out_valid", {255'd0, out_valid}, 256'd0);
    check_eq("arst_in_ready", {255'd0, in_ready}, 256'd1);
    check_eq("arst_out_data", {128'd0, out_data}, 256'd0);
    sb_q.delete();
    stalled   = 1'b0;
    in_valid  = 1'b1;
    in_data   = VecC;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("rst_ignores_in", {255'd0, out_valid}, 256'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    step(1'b1, VecC, 1'b0, 4'hc, 1'b1, VecCs, acc);
    step(1'b0, 128'd0, 1'b0, 4'd0, 1'b1, 128'd0, acc);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
